imem_access_ctrl: RTL and testbench

- Owns the single port of the synchronous-read instruction memory and shares it between two requesters: the core fetch stage (read-only) and the program loader/debug port (read/write).
- Sequences boot: after reset only the loader may access memory, and core fetch is released once the loader signals completion.
- Provides fixed-priority arbitration with a starvation bound, plus fault detection for bad fetch addresses.

---
 rtl/imem_access_ctrl.sv | 150 +++++++++++++++
 tb/tb_imem_access_ctrl.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_access_ctrl.sv
// Instruction memory access controller: shares the single memory port between core
// fetch and the loader, gates fetch until the program image is loaded, bounds loader
// bursts while a fetch waits, and turns bad fetch addresses into NOP responses.
`ifndef WORD_BITS
`define WORD_BITS 32
`endif
`ifndef DWORD_BITS
`define DWORD_BITS 64
`endif

module imem_access_ctrl #(
    parameter int unsigned            ADDR_BITS    = 10,
    parameter int unsigned            MAX_LD_BURST = 4,
    parameter logic [`WORD_BITS-1:0]  FAULT_INSTR  = 32'h0000_0013
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      fetch_req_valid,
    output logic                      fetch_req_ready,
    input  logic [`DWORD_BITS-1:0]    fetch_pc,
    output logic                      fetch_rsp_valid,
    output logic [`WORD_BITS-1:0]     fetch_rsp_instr,
    output logic                      fetch_rsp_fault,
    input  logic                      ld_req_valid,
    output logic                      ld_req_ready,
    input  logic                      ld_req_we,
    input  logic [ADDR_BITS-1:0]      ld_req_addr,
    input  logic [`WORD_BITS-1:0]     ld_req_wdata,
    output logic                      ld_rsp_valid,
    output logic [`WORD_BITS-1:0]     ld_rsp_rdata,
    input  logic                      ld_done,
    output logic                      boot_done,
    output logic                      mem_en,
    output logic                      mem_we,
    output logic [ADDR_BITS-3:0]      mem_word_id,
    output logic [`WORD_BITS-1:0]     mem_wdata,
    input  logic [`WORD_BITS-1:0]     mem_rdata
);

    localparam int unsigned     CntW   = $clog2(MAX_LD_BURST + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(MAX_LD_BURST);

    typedef enum logic [0:0] {StBoot, StRun} state_e;

    state_e                  state_q;
    logic [CntW-1:0]         cnt_q, cnt_d;
    logic                    fetch_pend_q, fetch_fault_q;
    logic [`WORD_BITS-1:0]   fetch_instr_q;
    logic                    ld_pend_q;
    logic [`WORD_BITS-1:0]   ld_rdata_q;
    logic                    fetch_grant, ld_grant, fetch_fault;

    // Byte offset within a word is irrelevant for the loader.
    logic unused_ld_addr_bits;
    assign unused_ld_addr_bits = ^ld_req_addr[1:0];

    // Arbitration, fault decode and memory port drive for the current grant.
    always_comb begin
        if (state_q == StBoot) begin
            ld_req_ready    = 1'b1;
            fetch_req_ready = 1'b0;
        end else begin
            ld_req_ready    = ld_req_valid & ~(fetch_req_valid & (cnt_q == CntMax));
            fetch_req_ready = fetch_req_valid & ~ld_req_ready;
        end
        ld_grant    = ld_req_valid & ld_req_ready;
        fetch_grant = fetch_req_valid & fetch_req_ready;
        fetch_fault = (fetch_pc[1:0] != 2'b00) ||
                      (fetch_pc[`DWORD_BITS-1:ADDR_BITS] != '0);

        mem_en      = ld_grant | (fetch_grant & ~fetch_fault);
        mem_we      = ld_grant & ld_req_we;
        mem_word_id = ld_grant ? ld_req_addr[ADDR_BITS-1:2] : fetch_pc[ADDR_BITS-1:2];
        mem_wdata   = ld_req_wdata;
    end

    // Loader burst counter: counts grants that make a pending fetch wait.
    always_comb begin
        cnt_d = '0;
        if (state_q == StRun) begin
            if (!fetch_req_valid || fetch_grant) begin
                cnt_d = '0;
            end else if (ld_grant && cnt_q != CntMax) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                cnt_d = cnt_q;
            end
        end
    end

    // Boot sequencing FSM; boot_done is registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= StBoot;
            boot_done <= 1'b0;
        end else begin
            case (state_q)
                StBoot: begin
                    if (ld_done) begin
                        state_q   <= StRun;
                        boot_done <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= StRun;
                    boot_done <= 1'b1;
                end
            endcase
        end
    end

    // Burst counter and response pipeline; reset drops any in-flight response.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q         <= '0;
            fetch_pend_q  <= 1'b0;
            fetch_fault_q <= 1'b0;
            fetch_instr_q <= '0;
            ld_pend_q     <= 1'b0;
            ld_rdata_q    <= '0;
        end else begin
            cnt_q        <= cnt_d;
            fetch_pend_q <= fetch_grant;
            if (fetch_grant) begin
                fetch_fault_q <= fetch_fault;
            end
            if (fetch_pend_q) begin
                fetch_instr_q <= fetch_rsp_instr;
            end
            ld_pend_q <= ld_grant & ~ld_req_we;
            if (ld_pend_q) begin
                ld_rdata_q <= mem_rdata;
            end
        end
    end

    // Read data arrives the cycle after the access; hold it afterwards.
    always_comb begin
        fetch_rsp_valid = fetch_pend_q;
        fetch_rsp_fault = fetch_fault_q;
        if (fetch_pend_q) begin
            fetch_rsp_instr = fetch_fault_q ? FAULT_INSTR : mem_rdata;
        end else begin
            fetch_rsp_instr = fetch_instr_q;
        end
        ld_rsp_valid = ld_pend_q;
        ld_rsp_rdata = ld_pend_q ? mem_rdata : ld_rdata_q;
    end

endmodule

// File: tb/tb_imem_access_ctrl.sv
// Scoreboard bench for imem_access_ctrl: directed stimulus pushes expected responses,
// an independent monitor pops and compares them as responses appear.
`ifndef WORD_BITS
`define WORD_BITS 32
`endif
`ifndef DWORD_BITS
`define DWORD_BITS 64
`endif

module tb_imem_access_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_req_valid = 1'b0;
    logic        fetch_req_ready;
    logic [63:0] fetch_pc = '0;
    logic        fetch_rsp_valid;
    logic [31:0] fetch_rsp_instr;
    logic        fetch_rsp_fault;
    logic        ld_req_valid = 1'b0;
    logic        ld_req_ready;
    logic        ld_req_we = 1'b0;
    logic [9:0]  ld_req_addr = '0;
    logic [31:0] ld_req_wdata = '0;
    logic        ld_rsp_valid;
    logic [31:0] ld_rsp_rdata;
    logic        ld_done = 1'b0;
    logic        boot_done;
    logic        mem_en;
    logic        mem_we;
    logic [7:0]  mem_word_id;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    imem_access_ctrl #(
        .ADDR_BITS(10),
        .MAX_LD_BURST(4),
        .FAULT_INSTR(32'h0000_0013)
    ) dut (
        .clk(clk), .reset(reset),
        .fetch_req_valid(fetch_req_valid), .fetch_req_ready(fetch_req_ready),
        .fetch_pc(fetch_pc), .fetch_rsp_valid(fetch_rsp_valid),
        .fetch_rsp_instr(fetch_rsp_instr), .fetch_rsp_fault(fetch_rsp_fault),
        .ld_req_valid(ld_req_valid), .ld_req_ready(ld_req_ready), .ld_req_we(ld_req_we),
        .ld_req_addr(ld_req_addr), .ld_req_wdata(ld_req_wdata),
        .ld_rsp_valid(ld_rsp_valid), .ld_rsp_rdata(ld_rsp_rdata), .ld_done(ld_done),
        .boot_done(boot_done), .mem_en(mem_en), .mem_we(mem_we),
        .mem_word_id(mem_word_id), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    // Synchronous-read memory model.
    logic [31:0] mem [256];
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 32'hA000_0000 + i;
        mem_rdata = '0;
    end
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem[mem_word_id] <= mem_wdata;
            else        mem_rdata <= mem[mem_word_id];
        end
    end

    typedef struct packed {
        logic [31:0] instr;
        logic        fault;
    } fexp_t;

    fexp_t       fq[$];
    logic [31:0] lq[$];
    int          ncmp = 0;
    int          nfail = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic push_f(input logic [31:0] instr, input logic fault);
        fexp_t e;
        e.instr = instr;
        e.fault = fault;
        fq.push_back(e);
    endtask

    // Drive one cycle of request inputs mid-cycle, then settle.
    task automatic cyc(input logic fv, input logic [63:0] pc, input logic lv, input logic we,
                       input logic [9:0] addr, input logic [31:0] wd, input logic done);
        @(negedge clk);
        fetch_req_valid = fv;
        fetch_pc        = pc;
        ld_req_valid    = lv;
        ld_req_we       = we;
        ld_req_addr     = addr;
        ld_req_wdata    = wd;
        ld_done         = done;
        #1;
    endtask

    // Monitor: every expected response must appear exactly one cycle after its grant.
    fexp_t       mon_f;
    logic [31:0] mon_l;
    always @(posedge clk) begin
        #1;
        if (fetch_rsp_valid === 1'b1) begin
            if (fq.size() == 0) begin
                ncmp++; nfail++;
                $display("FAIL fetch_rsp_unexpected: valid=1 instr=%h, required no response",
                         fetch_rsp_instr);
            end else begin
                mon_f = fq.pop_front();
                chk("fetch_rsp_instr", 64'(fetch_rsp_instr), 64'(mon_f.instr));
                chk("fetch_rsp_fault", 64'(fetch_rsp_fault), 64'(mon_f.fault));
            end
        end else if (fq.size() != 0) begin
            mon_f = fq.pop_front();
            ncmp++; nfail++;
            $display("FAIL fetch_rsp_missing: valid=%b, required response instr=%h",
                     fetch_rsp_valid, mon_f.instr);
        end
        if (ld_rsp_valid === 1'b1) begin
            if (lq.size() == 0) begin
                ncmp++; nfail++;
                $display("FAIL ld_rsp_unexpected: valid=1 rdata=%h, required no response",
                         ld_rsp_rdata);
            end else begin
                mon_l = lq.pop_front();
                chk("ld_rsp_rdata", 64'(ld_rsp_rdata), 64'(mon_l));
            end
        end else if (lq.size() != 0) begin
            mon_l = lq.pop_front();
            ncmp++; nfail++;
            $display("FAIL ld_rsp_missing: valid=%b, required rdata=%h", ld_rsp_valid, mon_l);
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required normal end");
        $fatal(1, "watchdog");
    end

    logic we;
    logic lg;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        chk("rst_boot_done", 64'(boot_done), 64'd0);
        chk("rst_fetch_rsp_valid", 64'(fetch_rsp_valid), 64'd0);
        chk("rst_ld_rsp_valid", 64'(ld_rsp_valid), 64'd0);
        chk("rst_fetch_rsp_instr", 64'(fetch_rsp_instr), 64'd0);
        chk("rst_ld_rsp_rdata", 64'(ld_rsp_rdata), 64'd0);
        chk("rst_fetch_rsp_fault", 64'(fetch_rsp_fault), 64'd0);
        chk("rst_mem_en", 64'(mem_en), 64'd0);
        chk("rst_mem_we", 64'(mem_we), 64'd0);
        reset = 1'b0;

        // BOOT: loader writes/reads, fetch held off
        cyc(1, 64'h0, 1, 1, 10'h3FC, 32'h1234_5678, 0);
        chk("boot_fetch_ready_wr", 64'(fetch_req_ready), 64'd0);
        chk("boot_ld_ready_wr", 64'(ld_req_ready), 64'd1);
        chk("boot_mem_en_wr", 64'(mem_en), 64'd1);
        chk("boot_mem_we_wr", 64'(mem_we), 64'd1);
        chk("boot_mem_word_wr", 64'(mem_word_id), 64'hFF);
        cyc(1, 64'h0, 1, 0, 10'h3FD, 32'h0, 0);
        chk("boot_fetch_ready_rd", 64'(fetch_req_ready), 64'd0);
        chk("boot_mem_we_rd", 64'(mem_we), 64'd0);
        chk("boot_mem_word_rd", 64'(mem_word_id), 64'hFF);
        lq.push_back(32'h1234_5678);
        cyc(1, 64'h0, 1, 1, 10'h000, 32'hDEAD_BEEF, 0);
        chk("boot_fetch_ready_wr0", 64'(fetch_req_ready), 64'd0);
        cyc(1, 64'h0, 0, 0, 10'h000, 32'h0, 1);
        chk("boot_fetch_ready_done", 64'(fetch_req_ready), 64'd0);
        chk("boot_done_during", 64'(boot_done), 64'd0);
        cyc(1, 64'h0, 0, 0, 10'h000, 32'h0, 0);
        chk("run_boot_done", 64'(boot_done), 64'd1);
        chk("run_fetch_ready", 64'(fetch_req_ready), 64'd1);
        chk("run_fetch_mem_en", 64'(mem_en), 64'd1);
        chk("run_fetch_mem_we", 64'(mem_we), 64'd0);
        push_f(32'hDEAD_BEEF, 1'b0);

        // Starvation bound: L,L,L,L,F,L,L,L,L,F
        for (int i = 0; i < 10; i++) begin
            we = i[0];
            cyc(1, 64'h8, 1, we, we ? 10'h190 : 10'h010, 32'hC0DE_0000 + i, 0);
            lg = (i != 4) && (i != 9);
            chk($sformatf("starve_ld_ready_%0d", i), 64'(ld_req_ready), 64'(lg));
            chk($sformatf("starve_fetch_ready_%0d", i), 64'(fetch_req_ready), 64'(!lg));
            chk($sformatf("starve_mem_we_%0d", i), 64'(mem_we), 64'(lg && we));
            if (lg && !we) lq.push_back(32'hA000_0004);
            if (!lg) push_f(32'hA000_0002, 1'b0);
        end

        // Faults
        cyc(1, 64'h2, 0, 0, 10'h0, 32'h0, 0);
        chk("fault_misalign_ready", 64'(fetch_req_ready), 64'd1);
        chk("fault_misalign_mem_en", 64'(mem_en), 64'd0);
        push_f(32'h0000_0013, 1'b1);
        cyc(1, 64'h400, 0, 0, 10'h0, 32'h0, 0);
        chk("fault_range_ready", 64'(fetch_req_ready), 64'd1);
        chk("fault_range_mem_en", 64'(mem_en), 64'd0);
        push_f(32'h0000_0013, 1'b1);
        cyc(1, 64'h8000_0000_0000_0000, 0, 0, 10'h0, 32'h0, 0);
        chk("fault_high_mem_en", 64'(mem_en), 64'd0);
        push_f(32'h0000_0013, 1'b1);
        cyc(1, 64'h3FC, 0, 0, 10'h0, 32'h0, 0);
        chk("fault_top_mem_en", 64'(mem_en), 64'd1);
        chk("fault_top_word", 64'(mem_word_id), 64'hFF);
        push_f(32'h1234_5678, 1'b0);

        // Streaming fetch
        for (int i = 0; i < 5; i++) begin
            cyc(1, 64'(i * 4), 0, 0, 10'h0, 32'h0, 0);
            chk($sformatf("stream_ready_%0d", i), 64'(fetch_req_ready), 64'd1);
            chk($sformatf("stream_word_%0d", i), 64'(mem_word_id), 64'(i));
            push_f(i == 0 ? 32'hDEAD_BEEF : 32'hA000_0000 + i, 1'b0);
        end

        // Write then read the same word on consecutive cycles
        cyc(0, 64'h0, 1, 1, 10'h190, 32'h5555_AAAA, 0);
        chk("wr_rd_ld_ready_w", 64'(ld_req_ready), 64'd1);
        cyc(0, 64'h0, 1, 0, 10'h190, 32'h0, 0);
        chk("wr_rd_ld_ready_r", 64'(ld_req_ready), 64'd1);
        lq.push_back(32'h5555_AAAA);
        cyc(0, 64'h0, 0, 0, 10'h0, 32'h0, 0);
        chk("idle_mem_en", 64'(mem_en), 64'd0);

        // Reset mid-stream: response of the grant under reset is discarded
        cyc(1, 64'h0, 0, 0, 10'h0, 32'h0, 0);
        push_f(32'hDEAD_BEEF, 1'b0);
        cyc(1, 64'h4, 0, 0, 10'h0, 32'h0, 0);
        reset = 1'b1;
        cyc(1, 64'h0, 0, 0, 10'h0, 32'h0, 0);
        reset = 1'b0;
        chk("midrst_rsp_valid", 64'(fetch_rsp_valid), 64'd0);
        chk("midrst_boot_done", 64'(boot_done), 64'd0);
        chk("midrst_fetch_ready", 64'(fetch_req_ready), 64'd0);
        chk("midrst_ld_ready", 64'(ld_req_ready), 64'd1);
        chk("midrst_cnt", 64'(dut.cnt_q), 64'd0);
        cyc(0, 64'h0, 0, 0, 10'h0, 32'h0, 0);
        cyc(0, 64'h0, 0, 0, 10'h0, 32'h0, 0);

        chk("fetch_queue_empty", 64'(fq.size()), 64'd0);
        chk("ld_queue_empty", 64'(lq.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
